// File: rtl/tspp_fetch_stage.sv
// Fetch stage: owns the PC, issues instruction-memory reads and hands {pc, instr, npc}
// to execute through a one-entry slot, squashing wrong-path fetches on redirect.
module tspp_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0200,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic        imem_busy,
    input  logic [31:0] imem_rdata,
    input  logic        ex_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fe_valid,
    output logic [31:0] fe_pc,
    output logic [31:0] fe_instr,
    output logic [31:0] fe_npc,
    output logic        fe_misaligned
);

    typedef enum logic [2:0] {
        StFetch,
        StHold,
        StDrain,
        StFault,
        StIdle
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        fe_valid_q, fe_valid_d;
    logic [31:0] fe_pc_q, fe_pc_d;
    logic [31:0] fe_instr_q, fe_instr_d;
    logic [31:0] fe_npc_q, fe_npc_d;
    logic        fe_mis_q, fe_mis_d;

    logic        done;
    logic        consume;
    logic        redirect_mis;
    logic [31:0] drain_target;
    logic        load_en;
    logic [31:0] load_pc;
    logic [31:0] load_instr;
    logic        load_mis;

    // The abandoned read keeps pc_q as its address, so DRAIN needs no separate register.
    assign imem_ren     = !RST && (state_q == StFetch || state_q == StDrain);
    assign imem_addr    = pc_q;
    assign done         = imem_ren && !imem_busy;
    assign consume      = fe_valid_q && !ex_stall;
    assign redirect_mis = redirect_pc[1:0] != 2'b00;
    assign drain_target = redirect_valid ? redirect_pc : pend_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        fe_valid_d   = fe_valid_q;
        fe_pc_d      = fe_pc_q;
        fe_instr_d   = fe_instr_q;
        fe_npc_d     = fe_npc_q;
        fe_mis_d     = fe_mis_q;
        load_en      = 1'b0;
        load_pc      = pc_q;
        load_instr   = imem_rdata;
        load_mis     = 1'b0;

        if (consume || redirect_valid) begin
            fe_valid_d = 1'b0;
        end

        unique case (state_q)
            StFetch: begin
                if (redirect_valid) begin
                    if (!done) begin
                        // Never drop a request mid-transfer; finish it, then jump.
                        pend_d  = redirect_pc;
                        state_d = StDrain;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = redirect_mis ? StFault : StFetch;
                    end
                end else if (done) begin
                    pc_d = pc_q + 32'd4;
                    if (!fe_valid_q || consume) begin
                        load_en = 1'b1;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = redirect_mis ? StFault : StFetch;
                end else if (consume) begin
                    load_en    = 1'b1;
                    load_pc    = skid_pc_q;
                    load_instr = skid_instr_q;
                    state_d    = StFetch;
                end
            end
            StDrain: begin
                if (done) begin
                    pc_d = drain_target;
                    if (drain_target[1:0] != 2'b00) begin
                        load_en    = 1'b1;
                        load_pc    = drain_target;
                        load_instr = NOP_INSTR;
                        load_mis   = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    pend_d = drain_target;
                end
            end
            StFault, StIdle: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = redirect_mis ? StFault : StFetch;
                end else if (state_q == StFault) begin
                    // Slot was cleared by the redirect that brought us here.
                    load_en    = 1'b1;
                    load_instr = NOP_INSTR;
                    load_mis   = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StFetch;
        endcase

        if (load_en) begin
            fe_valid_d = 1'b1;
            fe_pc_d    = load_pc;
            fe_instr_d = load_instr;
            fe_npc_d   = load_pc + 32'd4;
            fe_mis_d   = load_mis;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            pend_q       <= 32'd0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= 32'd0;
            fe_valid_q   <= 1'b0;
            fe_pc_q      <= 32'd0;
            fe_instr_q   <= 32'd0;
            fe_npc_q     <= 32'd0;
            fe_mis_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            fe_valid_q   <= fe_valid_d;
            fe_pc_q      <= fe_pc_d;
            fe_instr_q   <= fe_instr_d;
            fe_npc_q     <= fe_npc_d;
            fe_mis_q     <= fe_mis_d;
        end
    end

    assign fe_valid      = fe_valid_q;
    assign fe_pc         = fe_pc_q;
    assign fe_instr      = fe_instr_q;
    assign fe_npc        = fe_npc_q;
    assign fe_misaligned = fe_mis_q;

endmodule

// File: tb/tb_tspp_fetch_stage.sv
// Bench for tspp_fetch_stage: expected slot contents are queued as stimulus is applied
// and compared whenever execute consumes the slot.
module tb_tspp_fetch_stage;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        imem_busy = 1'b0;
    logic [31:0] imem_rdata;
    logic        ex_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_instr;
    logic [31:0] fe_npc;
    logic        fe_misaligned;

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          consumed = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] addr_a;

    tspp_fetch_stage dut (
        .CLK           (CLK),
        .RST           (RST),
        .imem_ren      (imem_ren),
        .imem_addr     (imem_addr),
        .imem_busy     (imem_busy),
        .imem_rdata    (imem_rdata),
        .ex_stall      (ex_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fe_valid      (fe_valid),
        .fe_pc         (fe_pc),
        .fe_instr      (fe_instr),
        .fe_npc        (fe_npc),
        .fe_misaligned (fe_misaligned)
    );

    always #5 CLK = ~CLK;

    assign imem_rdata = imem_addr ^ XOR_KEY;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc  = start + 32'(4 * i);
            e.mis = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_fault(input logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.mis = 1'b1;
        exp_q.push_back(e);
    endtask

    // Scoreboard and bus-protocol monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("addr_hold", imem_addr, prev_addr);
                check_eq("ren_hold", {31'd0, imem_ren}, 32'd1);
            end
            prev_hold = imem_ren && imem_busy;
            prev_addr = imem_addr;
            if (imem_ren) check_eq("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (fe_valid && !ex_stall && !redirect_valid) begin
                consumed++;
                check_eq("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("sb_pc", fe_pc, e.pc);
                    check_eq("sb_instr", fe_instr, e.mis ? NOP : (e.pc ^ XOR_KEY));
                    check_eq("sb_npc", fe_npc, e.pc + 32'd4);
                    check_eq("sb_mis", {31'd0, fe_misaligned}, {31'd0, e.mis});
                end
            end
        end
    end

    initial begin
        // Reset values
        tick(2);
        check_eq("rst_valid", {31'd0, fe_valid}, 32'd0);
        check_eq("rst_pc", fe_pc, 32'd0);
        check_eq("rst_instr", fe_instr, 32'd0);
        check_eq("rst_npc", fe_npc, 32'd0);
        check_eq("rst_mis", {31'd0, fe_misaligned}, 32'd0);
        check_eq("rst_ren", {31'd0, imem_ren}, 32'd0);

        // Streaming at one instruction per cycle
        push_run(32'h200, 64);
        RST = 1'b0;
        #1;
        check_eq("first_ren", {31'd0, imem_ren}, 32'd1);
        check_eq("first_addr", imem_addr, 32'h200);
        tick(1);
        check_eq("first_valid", {31'd0, fe_valid}, 32'd1);
        check_eq("first_pc", fe_pc, 32'h200);
        check_eq("second_addr", imem_addr, 32'h204);
        tick(7);
        check_eq("throughput", 32'(consumed), 32'd7);

        // Stall with full slot: one read lands in the skid, then the bus idles
        ex_stall = 1'b1;
        tick(1);
        check_eq("hold_ren", {31'd0, imem_ren}, 32'd0);
        tick(2);
        check_eq("hold_ren2", {31'd0, imem_ren}, 32'd0);
        check_eq("hold_slot", fe_pc, 32'h21C);
        ex_stall = 1'b0;
        tick(1);
        check_eq("skid_slot", fe_pc, 32'h220);
        check_eq("after_hold_addr", imem_addr, 32'h224);
        tick(3);

        // Redirect while a read is in flight: read completes and is discarded
        imem_busy = 1'b1;
        addr_a = imem_addr;
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        exp_q.delete();
        push_run(32'h400, 64);
        tick(1);
        redirect_valid = 1'b0;
        check_eq("drain_addr", imem_addr, addr_a);
        check_eq("drain_ren", {31'd0, imem_ren}, 32'd1);
        tick(1);
        check_eq("drain_valid", {31'd0, fe_valid}, 32'd0);
        imem_busy = 1'b0;
        tick(1);
        check_eq("post_drain_addr", imem_addr, 32'h400);
        check_eq("post_drain_valid", {31'd0, fe_valid}, 32'd0);
        tick(4);

        // Redirect coincident with completion and stall
        redirect_valid = 1'b1;
        redirect_pc = 32'h1000;
        ex_stall = 1'b1;
        exp_q.delete();
        push_run(32'h1000, 64);
        tick(1);
        redirect_valid = 1'b0;
        check_eq("redir_valid", {31'd0, fe_valid}, 32'd0);
        check_eq("redir_addr", imem_addr, 32'h1000);
        tick(1);
        check_eq("redir_slot", fe_pc, 32'h1000);
        ex_stall = 1'b0;
        tick(3);

        // Misaligned target: fault slot, no bus activity
        redirect_valid = 1'b1;
        redirect_pc = 32'h402;
        exp_q.delete();
        push_fault(32'h402);
        tick(1);
        redirect_valid = 1'b0;
        check_eq("mis_ren", {31'd0, imem_ren}, 32'd0);
        tick(1);
        check_eq("mis_valid", {31'd0, fe_valid}, 32'd1);
        check_eq("mis_pc", fe_pc, 32'h402);
        check_eq("mis_instr", fe_instr, NOP);
        check_eq("mis_flag", {31'd0, fe_misaligned}, 32'd1);
        check_eq("mis_ren2", {31'd0, imem_ren}, 32'd0);
        tick(2);
        check_eq("idle_ren", {31'd0, imem_ren}, 32'd0);
        check_eq("idle_valid", {31'd0, fe_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        exp_q.delete();
        push_run(32'h500, 64);
        tick(1);
        redirect_valid = 1'b0;
        check_eq("resume_ren", {31'd0, imem_ren}, 32'd1);
        check_eq("resume_addr", imem_addr, 32'h500);
        tick(3);

        // Address wrap, then reset during a busy read
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        exp_q.delete();
        push_run(32'hFFFF_FFF8, 16);
        tick(1);
        redirect_valid = 1'b0;
        check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        tick(2);
        check_eq("wrap_pc", fe_pc, 32'hFFFF_FFFC);
        check_eq("wrap_npc", fe_npc, 32'd0);
        check_eq("wrap_addr", imem_addr, 32'd0);
        imem_busy = 1'b1;
        tick(1);
        check_eq("busy_ren", {31'd0, imem_ren}, 32'd1);
        RST = 1'b1;
        exp_q.delete();
        #1;
        check_eq("rst_mid_ren", {31'd0, imem_ren}, 32'd0);
        check_eq("rst_mid_valid", {31'd0, fe_valid}, 32'd0);
        tick(1);
        RST = 1'b0;
        imem_busy = 1'b0;
        push_run(32'h200, 64);
        #1;
        check_eq("restart_addr", imem_addr, 32'h200);
        check_eq("restart_ren", {31'd0, imem_ren}, 32'd1);
        tick(1);
        check_eq("restart_slot", fe_pc, 32'h200);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
